mem_stage_hs: RTL and testbench
===============================

# mem_stage_hs

Handshaked, registered successor to the combinational MEM stage of the 5-stage RV32 pipeline. Sits between the EX/MEM register and writeback. Drives an external data memory over a req/ack interface with arbitrary latency and a bounded timeout. Stalls the pipeline while an access is outstanding, aligns and extends load data, generates store byte enables, and contains its own MEM/WB output register.

## Interface
- `ADDR_W`, default 32: data memory byte-address width (≥ 3).
- `TIMEOUT`, default 64: maximum cycles in WAIT without `dmem_ack` before a bus error is raised (1..255).
- `clk`  in  1  pipeline clock; all logic on rising edge.
- `rst`  in  1  reset; **synchronous and active-high**.
- `en`  in  1  pipeline enable. When 0: no new op accepted; wb outputs hold.
- `flush`  in  1  kills the op presented this cycle (IDLE only).
- `in_valid`  in  1  EX/MEM holds a valid instruction.
- `alu_result`  in  ADDR_W  effective address, or ALU result for non-memory ops (low 32 bits used as result).
- `rs2_data`  in  32  store data.
- `rd`  in  5  destination register.
- `mem_read`, `mem_write`  in  1 each  load / store (never both).
- `load_type`  in  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU.
- `store_type`  in  2  00 SB, 01 SH, 10 SW.
- `wb_reg_file`  in  1  instruction writes rd.
- `memtoreg`  in  1  writeback source is memory.
- `dmem_req`  out  1  access request, held until ack.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  ADDR_W  word address (bits [1:0] = 0).
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_be`  out  4  byte enables.
- `dmem_ack`  in  1  access complete; `dmem_rdata` valid this cycle.
- `dmem_rdata`  in  32  read word.
- `stall`  out  1  hold EX/MEM and upstream stages.
- `wb_valid`  out  1  wb_* describe a retiring instruction.
- `wb_we`  out  1  register-file write enable.
- `wb_rd`  out  5  destination register.
- `wb_data`  out  32  writeback value.
- `misalign`  out  1  one-cycle pulse: misaligned access trapped.
- `bus_err`  out  1  one-cycle pulse: access timed out.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset goes to IDLE with all outputs 0 and the timeout counter at 0.
- **IDLE**, acceptance condition `in_valid & en & ~flush`:
  - Non-memory op: register `wb_data=alu_result[31:0]`, `wb_we=wb_reg_file`, `wb_rd=rd`, `wb_valid=1`.
  - Memory op: latch addr/we/be/wdata/rd/load_type, go to WAIT. `stall` is asserted combinationally this cycle.
  - No acceptance with `en=1`: `wb_valid`, `wb_we` ← 0.
- **WAIT**:
  - `dmem_req=1`, `stall=1`; the counter increments each cycle.
  - On `dmem_ack`: the formatted result goes to the wb registers (`wb_we = wb_reg_file & memtoreg` for loads, 0 for stores), `wb_valid=1`, counter cleared, next state IDLE. If `en=0` in that cycle, the result is buffered and the next state is DONE.
  - On counter reaching TIMEOUT without ack: drop `dmem_req`, pulse `bus_err`, write `wb_valid=1`, `wb_we=0`, return to IDLE.
  - `stall` deasserts in the ack/timeout cycle. `flush` is ignored in WAIT.
- **DONE**: `stall=1`. Transfer the buffer to wb when `en=1`, then go to IDLE.
- **Store lanes**:
  - SB: `be = 1<<addr[1:0]`, data = byte ×4.
  - SH: `be = addr[1] ? 1100 : 0011`, data = half ×2.
  - SW: `be = 1111`.
- **Load extract**: select the byte/half by `addr[1:0]`. LB/LH sign-extend; LBU/LHU zero-extend; LW uses the full word.
- **Misalignment**: LH/LHU/SH with `addr[0]=1`, or LW/SW with `addr[1:0]≠0`. Handling is set by the macro (see Configuration).
- **`rst` mid-transaction**: FSM to IDLE, `dmem_req` drops the next cycle, the pending result is discarded, no `bus_err`.

## Timing
- Non-memory op: wb outputs valid 1 cycle after acceptance.
- Memory op: `dmem_req` rises the cycle after acceptance. wb outputs are valid the cycle after `dmem_ack`. Minimum latency is 2 cycles (ack in the first WAIT cycle).
- `dmem_addr/we/be/wdata` stay stable while `dmem_req=1`.
- `stall` is combinational from state and inputs and has no register delay.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A misaligned op issues no request and pulses `misalign` one cycle after acceptance.
  - wb gets `wb_valid=1`, `wb_we=0`; 1-cycle latency, no stall.
- Undefined:
  - Offending low address bits are forced to 0 (half: bit 0; word: bits [1:0]) and the access proceeds normally.
  - `misalign` is tied to 0.

## Test plan
- ADD result `0x1234`, `rd=5`, no mem op -> next cycle `wb_valid=1`, `wb_we=1`, `wb_rd=5`, `wb_data=0x1234`, `stall=0`.
- SB addr `0x103`, `rs2=0xAB` -> `dmem_req`, `dmem_we=1`, `dmem_addr=0x100`, `dmem_be=1000`, `dmem_wdata=0xABABABAB`; stall held until ack.
- LH addr `0x102`, ack after 3 cycles with rdata `0x8001_0000` -> `stall` high for 4 cycles, then `wb_data=0xFFFF8001`; LHU same -> `0x00008001`.
- LW with no ack, `TIMEOUT=64` -> `bus_err` pulse after 64 WAIT cycles, `dmem_req` drops, `wb_we=0`, FSM back in IDLE.
- LW addr `0x102` -> with macro: `misalign` pulse, no `dmem_req`, `wb_we=0`; without: request to `0x100`, normal load.
- `rst` asserted during WAIT, then `flush` with valid ADD in IDLE -> `dmem_req` drops next cycle, no `bus_err`; flushed ADD gives `wb_valid=0`.

Source files
------------

// File: rtl/mem_stage_hs_if.sv
// Data-memory req/ack bus used by mem_stage_hs.
// The master drives a request that is held until the slave answers with ack.
interface mem_stage_hs_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [3:0]        dmem_be;
    logic              dmem_ack;
    logic [31:0]       dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_hs.sv
// Handshaked MEM stage with built-in MEM/WB register, bus timeout and load/store lane handling.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module mem_stage_hs #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_flush,
    input  logic              i_in_valid,
    input  logic [ADDR_W-1:0] i_alu_result,
    input  logic [31:0]       i_rs2_data,
    input  logic [4:0]        i_rd,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [2:0]        i_load_type,
    input  logic [1:0]        i_store_type,
    input  logic              i_wb_reg_file,
    input  logic              i_memtoreg,
    mem_stage_hs_if.master    dmem,
    output logic              o_stall,
    output logic              o_wb_valid,
    output logic              o_wb_we,
    output logic [4:0]        o_wb_rd,
    output logic [31:0]       o_wb_data,
    output logic              o_misalign,
    output logic              o_bus_err
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [4:0]        r_rd;
    logic [2:0]        r_ld_type;
    logic              r_ld_wb;
    logic [7:0]        r_cnt;
    logic [31:0]       r_buf_data;
    logic              r_buf_we;
    logic              r_wb_valid, r_wb_we;
    logic [4:0]        r_wb_rd;
    logic [31:0]       r_wb_data;
    logic              r_misalign, r_bus_err;

    logic              w_is_mem, w_accept, w_trap, w_stall;
    logic              w_size_b, w_size_h, w_size_w;
    logic [ADDR_W-1:0] w_addr_fix;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata, w_load_data;
    logic              w_ack, w_tmo;

    assign w_is_mem = i_mem_read | i_mem_write;
    assign w_accept = (r_state == StIdle) & i_in_valid & i_en & ~i_flush;

    assign w_size_b = i_mem_read ? (i_load_type == 3'b000 || i_load_type == 3'b011)
                                 : (i_store_type == 2'b00);
    assign w_size_h = i_mem_read ? (i_load_type == 3'b001 || i_load_type == 3'b100)
                                 : (i_store_type == 2'b01);
    assign w_size_w = ~w_size_b & ~w_size_h;

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_trap = w_is_mem & ((w_size_h & i_alu_result[0]) |
                                (w_size_w & (|i_alu_result[1:0])));
`else
    assign w_trap = 1'b0;
`endif

    // Without trapping, offending low address bits are simply cleared.
    always_comb begin
        w_addr_fix = i_alu_result;
        if (w_size_h) w_addr_fix[0] = 1'b0;
        if (w_size_w) w_addr_fix[1:0] = 2'b00;
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_rs2_data;
        if (i_mem_write) begin
            case (i_store_type)
                2'b00: begin
                    w_be    = 4'b0001 << w_addr_fix[1:0];
                    w_wdata = {4{i_rs2_data[7:0]}};
                end
                2'b01: begin
                    w_be    = w_addr_fix[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{i_rs2_data[15:0]}};
                end
                default: w_be = 4'b1111;
            endcase
        end
    end

    function automatic logic [31:0] f_load(input logic [31:0] word, input logic [1:0] ofs,
                                           input logic [2:0] ltype);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{ofs, 3'b000} +: 8];
        h = ofs[1] ? word[31:16] : word[15:0];
        case (ltype)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b011:  return {24'h0, b};
            3'b100:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

    assign w_load_data = f_load(dmem.dmem_rdata, r_addr[1:0], r_ld_type);
    assign w_ack       = (r_state == StWait) & dmem.dmem_ack;
    assign w_tmo       = (r_state == StWait) & ~dmem.dmem_ack & (r_cnt == 8'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_accept && w_is_mem && !w_trap) begin
                    w_state_nxt = StWait;
                    w_stall     = 1'b1;
                end
            end
            StWait: begin
                if (w_ack) begin
                    w_state_nxt = i_en ? StIdle : StDone;
                end else if (w_tmo) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_stall = 1'b1;
                end
            end
            StDone: begin
                w_stall = 1'b1;
                if (i_en) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_be       <= 4'b0;
            r_wdata    <= 32'h0;
            r_rd       <= 5'h0;
            r_ld_type  <= 3'b0;
            r_ld_wb    <= 1'b0;
            r_cnt      <= 8'h0;
            r_buf_data <= 32'h0;
            r_buf_we   <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_wb_rd    <= 5'h0;
            r_wb_data  <= 32'h0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        if (w_is_mem && !w_trap) begin
                            r_addr     <= w_addr_fix;
                            r_we       <= i_mem_write;
                            r_be       <= w_be;
                            r_wdata    <= w_wdata;
                            r_rd       <= i_rd;
                            r_ld_type  <= i_load_type;
                            r_ld_wb    <= i_mem_read & i_wb_reg_file & i_memtoreg;
                            r_cnt      <= 8'h0;
                            r_wb_valid <= 1'b0;
                            r_wb_we    <= 1'b0;
                        end else begin
                            r_wb_valid <= 1'b1;
                            r_wb_rd    <= i_rd;
                            r_wb_we    <= w_trap ? 1'b0 : i_wb_reg_file;
                            r_wb_data  <= w_trap ? 32'h0 : 32'(i_alu_result);
                            r_misalign <= w_trap;
                        end
                    end else if (i_en) begin
                        r_wb_valid <= 1'b0;
                        r_wb_we    <= 1'b0;
                    end
                end
                StWait: begin
                    if (dmem.dmem_ack) begin
                        r_cnt <= 8'h0;
                        if (i_en) begin
                            r_wb_valid <= 1'b1;
                            r_wb_we    <= r_ld_wb;
                            r_wb_rd    <= r_rd;
                            r_wb_data  <= w_load_data;
                        end else begin
                            r_buf_data <= w_load_data;
                            r_buf_we   <= r_ld_wb;
                        end
                    end else if (w_tmo) begin
                        r_cnt      <= 8'h0;
                        r_bus_err  <= 1'b1;
                        r_wb_valid <= 1'b1;
                        r_wb_we    <= 1'b0;
                        r_wb_rd    <= r_rd;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                StDone: begin
                    if (i_en) begin
                        r_wb_valid <= 1'b1;
                        r_wb_we    <= r_buf_we;
                        r_wb_rd    <= r_rd;
                        r_wb_data  <= r_buf_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmem.dmem_req   = (r_state == StWait);
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign dmem.dmem_wdata = r_wdata;
    assign dmem.dmem_be    = r_be;

    assign o_stall    = w_stall;
    assign o_wb_valid = r_wb_valid;
    assign o_wb_we    = r_wb_we;
    assign o_wb_rd    = r_wb_rd;
    assign o_wb_data  = r_wb_data;
    assign o_misalign = r_misalign;
    assign o_bus_err  = r_bus_err;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Randomized self-checking bench for mem_stage_hs; the bench acts as the data memory.
// Follows the DUT build: expectations switch on MEM_MISALIGN_TRAP_EN.
module tb_mem_stage_hs;

    localparam int unsigned TMO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1, flush = 1'b0, in_valid = 1'b0;
    logic [31:0] alu = 32'h0, rs2 = 32'h0;
    logic [4:0]  rd = 5'h0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  load_type = 3'b0;
    logic [1:0]  store_type = 2'b0;
    logic        wb_reg_file = 1'b0, memtoreg = 1'b0;
    logic        stall, wb_valid, wb_we, misalign, bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_fails  = 0;

    // Last retirement the model expects on the wb outputs.
    logic        m_valid = 1'b0, m_we = 1'b0, m_data_known = 1'b1;
    logic [31:0] m_data = 32'h0;

    mem_stage_hs_if #(.ADDR_W(32)) dmem_bus ();

    mem_stage_hs #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_flush      (flush),
        .i_in_valid   (in_valid),
        .i_alu_result (alu),
        .i_rs2_data   (rs2),
        .i_rd         (rd),
        .i_mem_read   (mem_read),
        .i_mem_write  (mem_write),
        .i_load_type  (load_type),
        .i_store_type (store_type),
        .i_wb_reg_file(wb_reg_file),
        .i_memtoreg   (memtoreg),
        .dmem         (dmem_bus.master),
        .o_stall      (stall),
        .o_wb_valid   (wb_valid),
        .o_wb_we      (wb_we),
        .o_wb_rd      (wb_rd),
        .o_wb_data    (wb_data),
        .o_misalign   (misalign),
        .o_bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int op_bytes(input bit is_load, input logic [2:0] lt, input logic [1:0] st);
        if (is_load) return (lt == 3'd0 || lt == 3'd3) ? 1 : (lt == 3'd1 || lt == 3'd4) ? 2 : 4;
        return (st == 2'd0) ? 1 : (st == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [31:0] eff,
                                             input int nb, input logic [2:0] lt);
        logic [31:0] mask, v;
        if (nb == 4) return word;
        mask = (nb == 1) ? 32'hFF : 32'hFFFF;
        v = (word >> (8 * (eff % 4))) & mask;
        if ((lt == 3'd0 || lt == 3'd1) && (v & ((mask >> 1) + 1)) != 0) v = v | ~mask;
        return v;
    endfunction

    // Presents one op at an idle cycle and follows it to retirement.
    task automatic run_op(input bit is_load, input bit is_store, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] r, input logic [2:0] lt,
                          input logic [1:0] st, input bit wrf, input bit m2r, input int lat,
                          input int en_gap, input logic [31:0] rdata);
        int          nb, stall_cnt;
        bit          mis;
        logic [31:0] eff, waddr, exp_be, exp_wd, exp_wb;
        nb    = op_bytes(is_load, lt, st);
        mis   = (is_load || is_store) && (addr % nb) != 0;
        eff   = addr - (addr % nb);
        waddr = eff & 32'hFFFF_FFFC;
        exp_be = ((32'd1 << nb) - 1) << (eff % 4);
        exp_wd = (nb == 1) ? (data & 32'hFF) * 32'h0101_0101 :
                 (nb == 2) ? (data & 32'hFFFF) * 32'h0001_0001 : data;

        alu = addr; rs2 = data; rd = r; load_type = lt; store_type = st;
        mem_read = is_load; mem_write = is_store; wb_reg_file = wrf; memtoreg = m2r;
        in_valid = 1'b1; en = 1'b1; flush = 1'b0;
        #1;
        if (!(is_load || is_store)) begin
            check_eq("alu_stall", stall, 1'b0);
            tick();
            in_valid = 1'b0;
            check_eq("alu_wb_valid", wb_valid, 1'b1);
            check_eq("alu_wb_we", wb_we, wrf);
            check_eq("alu_wb_rd", wb_rd, r);
            check_eq("alu_wb_data", wb_data, addr);
            m_valid = 1'b1; m_we = wrf; m_data = addr; m_data_known = 1'b1;
            return;
        end
`ifdef MEM_MISALIGN_TRAP_EN
        if (mis) begin
            check_eq("trap_stall", stall, 1'b0);
            tick();
            in_valid = 1'b0;
            check_eq("trap_misalign", misalign, 1'b1);
            check_eq("trap_req", dmem_bus.dmem_req, 1'b0);
            check_eq("trap_wb_valid", wb_valid, 1'b1);
            check_eq("trap_wb_we", wb_we, 1'b0);
            m_valid = 1'b1; m_we = 1'b0; m_data_known = 1'b0;
            return;
        end
`endif
        check_eq("acc_stall", stall, 1'b1);
        stall_cnt = 1;
        tick();
        in_valid = 1'b0;
        alu = $urandom; rs2 = $urandom;
        check_eq("req_rise", dmem_bus.dmem_req, 1'b1);
        check_eq("req_we", dmem_bus.dmem_we, is_store);
        check_eq("req_addr", dmem_bus.dmem_addr, waddr);
        check_eq("wait_wb_valid", wb_valid, 1'b0);
        if (is_store) begin
            check_eq("req_be", dmem_bus.dmem_be, exp_be);
            check_eq("req_wdata", dmem_bus.dmem_wdata, exp_wd);
        end
        for (int k = 0; k < lat; k++) begin
            if (stall) stall_cnt++;
            tick();
            check_eq("req_held", dmem_bus.dmem_req, 1'b1);
            check_eq("addr_stable", dmem_bus.dmem_addr, waddr);
        end
        dmem_bus.dmem_ack = 1'b1;
        dmem_bus.dmem_rdata = rdata;
        if (en_gap > 0) en = 1'b0;
        #1;
        check_eq("ack_stall", stall, 1'b0);
        check_eq("stall_cycles", stall_cnt, lat + 1);
        tick();
        dmem_bus.dmem_ack = 1'b0;
        dmem_bus.dmem_rdata = $urandom;
        if (en_gap > 0) begin
            for (int g = 0; g < en_gap; g++) begin
                check_eq("done_stall", stall, 1'b1);
                check_eq("done_wb_hold", wb_valid, 1'b0);
                tick();
            end
            en = 1'b1;
            #1;
            check_eq("done_stall_en", stall, 1'b1);
            tick();
        end
        exp_wb = exp_load(rdata, eff, nb, lt);
        check_eq("mem_wb_valid", wb_valid, 1'b1);
        check_eq("mem_wb_we", wb_we, is_load & wrf & m2r);
        check_eq("mem_wb_rd", wb_rd, r);
        check_eq("req_drop", dmem_bus.dmem_req, 1'b0);
        if (is_load) check_eq("load_data", wb_data, exp_wb);
        m_valid = 1'b1; m_we = is_load & wrf & m2r; m_data = exp_wb; m_data_known = is_load;
    endtask

    task automatic hold_check();
        en = 1'b0; in_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        alu = $urandom; rd = 5'($urandom);
        #1;
        check_eq("hold_stall", stall, 1'b0);
        tick();
        check_eq("hold_valid", wb_valid, m_valid);
        check_eq("hold_we", wb_we, m_we);
        if (m_data_known) check_eq("hold_data", wb_data, m_data);
        in_valid = 1'b0; en = 1'b1;
    endtask

    task automatic flush_check();
        in_valid = 1'b1; flush = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        alu = 32'h55; rd = 5'd7; wb_reg_file = 1'b1;
        #1;
        check_eq("flush_stall", stall, 1'b0);
        tick();
        check_eq("flush_wb_valid", wb_valid, 1'b0);
        check_eq("flush_wb_we", wb_we, 1'b0);
        in_valid = 1'b0; flush = 1'b0;
        m_valid = 1'b0; m_we = 1'b0;
    endtask

    initial begin
        int  cnt;
        bit  done;
        int  kind;
        logic [31:0] a;
        dmem_bus.dmem_ack = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;

        tick(); tick();
        check_eq("rst_stall", stall, 1'b0);
        check_eq("rst_wb_valid", wb_valid, 1'b0);
        check_eq("rst_wb_we", wb_we, 1'b0);
        check_eq("rst_wb_rd", wb_rd, 5'h0);
        check_eq("rst_wb_data", wb_data, 32'h0);
        check_eq("rst_misalign", misalign, 1'b0);
        check_eq("rst_bus_err", bus_err, 1'b0);
        check_eq("rst_req", dmem_bus.dmem_req, 1'b0);
        check_eq("rst_be", dmem_bus.dmem_be, 4'h0);
        rst = 1'b0;
        tick();

        run_op(0, 0, 32'h1234, 0, 5'd5, 0, 0, 1, 0, 0, 0, 0);
        run_op(0, 1, 32'h103, 32'hAB, 5'd0, 0, 2'd0, 0, 0, 2, 0, 0);
        run_op(1, 0, 32'h102, 0, 5'd9, 3'd1, 0, 1, 1, 3, 0, 32'h8001_0000);
        check_eq("lh_const", wb_data, 32'hFFFF_8001);
        run_op(1, 0, 32'h102, 0, 5'd9, 3'd4, 0, 1, 1, 3, 0, 32'h8001_0000);
        check_eq("lhu_const", wb_data, 32'h0000_8001);
        run_op(1, 0, 32'h102, 0, 5'd3, 3'd2, 0, 1, 1, 1, 0, 32'hCAFE_F00D);
`ifndef MEM_MISALIGN_TRAP_EN
        check_eq("lw_forced", wb_data, 32'hCAFE_F00D);
`endif
        run_op(1, 0, 32'h40, 0, 5'd4, 3'd0, 0, 1, 1, 0, 2, 32'h0000_0080);

        // Load that never gets an ack.
        alu = 32'h200; mem_read = 1'b1; mem_write = 1'b0; load_type = 3'd2; rd = 5'd6;
        wb_reg_file = 1'b1; memtoreg = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cnt = 0; done = 0;
        while (!done && cnt < 300) begin
            if (dmem_bus.dmem_req) cnt++;
            if (!stall) done = 1;
            tick();
        end
        check_eq("tmo_cycles", cnt, TMO);
        check_eq("tmo_bus_err", bus_err, 1'b1);
        check_eq("tmo_req_drop", dmem_bus.dmem_req, 1'b0);
        check_eq("tmo_wb_valid", wb_valid, 1'b1);
        check_eq("tmo_wb_we", wb_we, 1'b0);
        tick();
        check_eq("tmo_pulse_end", bus_err, 1'b0);
        m_valid = 1'b0; m_we = 1'b0;

        // Reset in the middle of a wait.
        alu = 32'h300; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check_eq("pre_rst_req", dmem_bus.dmem_req, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_mid_req", dmem_bus.dmem_req, 1'b0);
        check_eq("rst_mid_bus_err", bus_err, 1'b0);
        check_eq("rst_mid_wb_valid", wb_valid, 1'b0);
        tick();
        check_eq("rst_mid_bus_err2", bus_err, 1'b0);
        m_valid = 1'b0; m_we = 1'b0; m_data = 32'h0; m_data_known = 1'b1;
        flush_check();

        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 5);
            a = $urandom;
            if (kind == 5) hold_check();
            else if (kind == 4) flush_check();
            else run_op(kind == 1, kind == 2, a, $urandom, 5'($urandom), 3'($urandom_range(0, 4)),
                        2'($urandom_range(0, 2)), 1'($urandom), 1'($urandom),
                        $urandom_range(0, 4),
                        ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
